// File: rtl/tetron_move_ctrl.sv
// Move sequencer for the falling tetromino: proposes a candidate pose, checks its four
// cells against the board bounds and occupancy RAM, then commits, rejects or locks and respawns.
module tetron_move_ctrl #(
  parameter int BOARD_W = 10,
  parameter int BOARD_H = 20,
  parameter int SPAWN_X = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_left,
  input  logic        req_right,
  input  logic        req_rot,
  input  logic        drop_tick,
  output logic        shp_active,
  output logic [2:0]  shp_rot,
  input  logic [39:0] shp_off,
  output logic        brd_rd_en,
  output logic [4:0]  brd_rd_x,
  output logic [4:0]  brd_rd_y,
  input  logic        brd_rd_occ,
  output logic [4:0]  piece_x,
  output logic [4:0]  piece_y,
  output logic [1:0]  piece_rot,
  output logic        busy,
  output logic        lock_pulse,
  output logic        game_over
);

  typedef enum logic [2:0] {
    S_IDLE, S_PROPOSE, S_CHECK, S_DECIDE, S_LOCK, S_SPAWN_CHK
  } state_t;

  typedef enum logic [1:0] {MV_DROP, MV_ROT, MV_LEFT, MV_RIGHT} move_t;

  localparam logic [4:0] W5  = 5'(BOARD_W);
  localparam logic [4:0] H5  = 5'(BOARD_H);
  localparam logic [4:0] SX5 = 5'(SPAWN_X);

  state_t     state_reg, state_next;
  move_t      move_reg, move_next;
  logic [1:0] k_reg, k_next;
  logic [4:0] cx_reg, cx_next, cy_reg, cy_next;
  logic [1:0] crot_reg, crot_next;
  logic       spawn_reg, spawn_next;
  logic       fail_reg, fail_next;
  logic       rd_pend_reg, rd_pend_next;
  logic       drop_pend_reg, drop_pend_next;
  logic       game_over_reg, game_over_next;
  logic [4:0] piece_x_reg, piece_x_next, piece_y_reg, piece_y_next;
  logic [1:0] piece_rot_reg, piece_rot_next;

  logic [4:0] hoff [4];
  logic [4:0] voff [4];
  logic [4:0] cell_x, cell_y;
  logic       cell_oob, occ_hit, fail_now;

  for (genvar gi = 0; gi < 4; gi++) begin : g_off
    assign voff[gi] = shp_off[10*gi +: 5];
    assign hoff[gi] = shp_off[10*gi + 5 +: 5];
  end

  // Negative offsets wrap to 27..31, so one unsigned compare covers both edges.
  assign cell_x   = cx_reg + hoff[k_reg];
  assign cell_y   = cy_reg + voff[k_reg];
  assign cell_oob = (cell_x >= W5) || (cell_y >= H5);
  assign occ_hit  = rd_pend_reg & brd_rd_occ;
  assign fail_now = fail_reg | occ_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= S_IDLE;
      move_reg      <= MV_DROP;
      k_reg         <= '0;
      cx_reg        <= '0;
      cy_reg        <= '0;
      crot_reg      <= '0;
      spawn_reg     <= 1'b0;
      fail_reg      <= 1'b0;
      rd_pend_reg   <= 1'b0;
      drop_pend_reg <= 1'b0;
      game_over_reg <= 1'b0;
      piece_x_reg   <= SX5;
      piece_y_reg   <= 5'd1;
      piece_rot_reg <= '0;
    end else begin
      state_reg     <= state_next;
      move_reg      <= move_next;
      k_reg         <= k_next;
      cx_reg        <= cx_next;
      cy_reg        <= cy_next;
      crot_reg      <= crot_next;
      spawn_reg     <= spawn_next;
      fail_reg      <= fail_next;
      rd_pend_reg   <= rd_pend_next;
      drop_pend_reg <= drop_pend_next;
      game_over_reg <= game_over_next;
      piece_x_reg   <= piece_x_next;
      piece_y_reg   <= piece_y_next;
      piece_rot_reg <= piece_rot_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    move_next      = move_reg;
    k_next         = k_reg;
    cx_next        = cx_reg;
    cy_next        = cy_reg;
    crot_next      = crot_reg;
    spawn_next     = spawn_reg;
    fail_next      = fail_reg;
    rd_pend_next   = 1'b0;
    drop_pend_next = drop_pend_reg;
    game_over_next = game_over_reg;
    piece_x_next   = piece_x_reg;
    piece_y_next   = piece_y_reg;
    piece_rot_next = piece_rot_reg;
    shp_rot        = {1'b0, crot_reg};
    brd_rd_en      = 1'b0;
    brd_rd_x       = '0;
    brd_rd_y       = '0;
    lock_pulse     = 1'b0;

    unique case (state_reg)
      S_IDLE: begin
        shp_rot    = {1'b0, piece_rot_reg};
        cx_next    = piece_x_reg;
        cy_next    = piece_y_reg;
        crot_next  = piece_rot_reg;
        spawn_next = 1'b0;
        if (game_over_reg) begin
          drop_pend_next = 1'b0;
        end else if (drop_pend_reg || drop_tick) begin
          move_next  = MV_DROP;
          cy_next    = piece_y_reg + 5'd1;
          state_next = S_PROPOSE;
        end else if (req_rot) begin
          move_next  = MV_ROT;
          crot_next  = piece_rot_reg + 2'd1;
          state_next = S_PROPOSE;
        end else if (req_left) begin
          move_next  = MV_LEFT;
          cx_next    = piece_x_reg - 5'd1;
          state_next = S_PROPOSE;
        end else if (req_right) begin
          move_next  = MV_RIGHT;
          cx_next    = piece_x_reg + 5'd1;
          state_next = S_PROPOSE;
        end
      end
      S_PROPOSE: begin
        k_next     = '0;
        fail_next  = 1'b0;
        state_next = S_CHECK;
      end
      S_CHECK: begin
        if (!cell_oob) begin
          brd_rd_en = 1'b1;
          brd_rd_x  = cell_x;
          brd_rd_y  = cell_y;
        end
        rd_pend_next = !cell_oob;
        fail_next    = fail_now | cell_oob;
        k_next       = k_reg + 2'd1;
        if (k_reg == 2'd3)
          state_next = spawn_reg ? S_SPAWN_CHK : S_DECIDE;
      end
      S_DECIDE: begin
        state_next = S_IDLE;
        if (move_reg == MV_DROP)
          drop_pend_next = 1'b0;
        if (!fail_now) begin
          piece_x_next   = cx_reg;
          piece_y_next   = cy_reg;
          piece_rot_next = crot_reg;
        end else if (move_reg == MV_DROP) begin
          state_next = S_LOCK;
        end
      end
      S_LOCK: begin
        lock_pulse     = 1'b1;
        piece_x_next   = SX5;
        piece_y_next   = 5'd1;
        piece_rot_next = '0;
        cx_next        = SX5;
        cy_next        = 5'd1;
        crot_next      = '0;
        spawn_next     = 1'b1;
        state_next     = S_PROPOSE;
      end
      S_SPAWN_CHK: begin
        if (fail_now)
          game_over_next = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase

    // Gravity ticks must never be lost, so a new tick wins over any clear this cycle.
    if (drop_tick)
      drop_pend_next = 1'b1;
  end

  assign shp_active = 1'b1;
  assign busy       = (state_reg != S_IDLE);
  assign game_over  = game_over_reg;
  assign piece_x    = piece_x_reg;
  assign piece_y    = piece_y_reg;
  assign piece_rot  = piece_rot_reg;

endmodule

// File: tb/tb_tetron_move_ctrl.sv
// Directed bench for tetron_move_ctrl: T-piece shaper model, occupancy RAM model,
// a table of single moves plus hand-written latency, lock, respawn and game-over sequences.
module tb_tetron_move_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_left = 1'b0, req_right = 1'b0, req_rot = 1'b0, drop_tick = 1'b0;
  logic        shp_active;
  logic [2:0]  shp_rot;
  logic [39:0] shp_off = '0;
  logic        brd_rd_en;
  logic [4:0]  brd_rd_x, brd_rd_y;
  logic        brd_rd_occ = 1'b0;
  logic [4:0]  piece_x, piece_y;
  logic [1:0]  piece_rot;
  logic        busy, lock_pulse, game_over;

  int checks = 0;
  int errors = 0;
  int rd_total = 0;
  int oob_reads = 0;
  logic occ_map [0:31][0:31];

  tetron_move_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .req_left(req_left), .req_right(req_right), .req_rot(req_rot), .drop_tick(drop_tick),
    .shp_active(shp_active), .shp_rot(shp_rot), .shp_off(shp_off),
    .brd_rd_en(brd_rd_en), .brd_rd_x(brd_rd_x), .brd_rd_y(brd_rd_y), .brd_rd_occ(brd_rd_occ),
    .piece_x(piece_x), .piece_y(piece_y), .piece_rot(piece_rot),
    .busy(busy), .lock_pulse(lock_pulse), .game_over(game_over)
  );

  always #5 clk = ~clk;

  // T piece: pivot, two arms, and a stem that points down in rotation 0.
  function automatic logic [39:0] shape(input logic [1:0] r);
    int h[4];
    int v[4];
    logic [39:0] s;
    case (r)
      2'd0: begin h = '{0, -1, 1, 0};  v = '{0, 0, 0, 1};  end
      2'd1: begin h = '{0, 0, 0, -1};  v = '{0, -1, 1, 0}; end
      2'd2: begin h = '{0, 1, -1, 0};  v = '{0, 0, 0, -1}; end
      default: begin h = '{0, 0, 0, 1}; v = '{0, 1, -1, 0}; end
    endcase
    s = '0;
    for (int k = 0; k < 4; k++) begin
      s[10*k +: 5]     = 5'(v[k]);
      s[10*k + 5 +: 5] = 5'(h[k]);
    end
    return s;
  endfunction

  always @(posedge clk) begin
    shp_off    <= shape(shp_rot[1:0]);
    brd_rd_occ <= brd_rd_en && occ_map[brd_rd_y][brd_rd_x];
    if (brd_rd_en) begin
      rd_total <= rd_total + 1;
      if (brd_rd_x >= 5'd10 || brd_rd_y >= 5'd20)
        oob_reads <= oob_reads + 1;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic clear_board();
    for (int y = 0; y < 32; y++)
      for (int x = 0; x < 32; x++)
        occ_map[y][x] = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // mv: 0 drop, 1 rot, 2 left, 3 right. Held for exactly one rising edge.
  task automatic pulse(input int mv);
    @(negedge clk);
    drop_tick = (mv == 0);
    req_rot   = (mv == 1);
    req_left  = (mv == 2);
    req_right = (mv == 3);
    @(posedge clk);
    #1;
    drop_tick = 1'b0; req_rot = 1'b0; req_left = 1'b0; req_right = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (busy) begin
      errors++;
      $display("FAIL %s: busy stuck, actual=1 required=0", name);
    end
  endtask

  typedef struct {
    int         mv;
    logic [4:0] ex;
    logic [4:0] ey;
    logic [1:0] erot;
    int         ereads;
  } vec_t;

  vec_t tbl [10];

  initial begin
    int rd0, n;
    logic seen;

    tbl[0] = '{3, 5'd6, 5'd1, 2'd0, 4};
    tbl[1] = '{1, 5'd6, 5'd1, 2'd1, 4};
    tbl[2] = '{1, 5'd6, 5'd1, 2'd2, 4};
    tbl[3] = '{1, 5'd6, 5'd1, 2'd3, 4};
    tbl[4] = '{1, 5'd6, 5'd1, 2'd0, 4};
    tbl[5] = '{0, 5'd6, 5'd2, 2'd0, 4};
    tbl[6] = '{3, 5'd7, 5'd2, 2'd0, 4};
    tbl[7] = '{3, 5'd8, 5'd2, 2'd0, 4};
    tbl[8] = '{3, 5'd8, 5'd2, 2'd0, 3};
    tbl[9] = '{2, 5'd7, 5'd2, 2'd0, 4};

    clear_board();
    do_reset();

    // Reset state
    @(negedge clk);
    check("rst_piece_x", piece_x, 4);
    check("rst_piece_y", piece_y, 1);
    check("rst_piece_rot", piece_rot, 0);
    check("rst_busy", busy, 0);
    check("rst_lock", lock_pulse, 0);
    check("rst_game_over", game_over, 0);
    check("rst_rd_en", brd_rd_en, 0);
    check("rst_shp_rot", shp_rot, 0);
    check("rst_shp_active", shp_active, 1);
    $display("reset: x=%0d y=%0d rot=%0d", piece_x, piece_y, piece_rot);

    // Latency of a right move: busy cycles 1..6, new position at cycle 7
    rd0 = rd_total;
    pulse(3);
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      check($sformatf("lat_busy_c%0d", c), busy, (c <= 6) ? 1 : 0);
      check($sformatf("lat_x_c%0d", c), piece_x, (c == 7) ? 5 : 4);
    end
    check("lat_reads", rd_total - rd0, 4);
    $display("latency right: x=%0d reads=%0d", piece_x, rd_total - rd0);

    // Table of single moves on an empty board
    for (int i = 0; i < 10; i++) begin
      rd0 = rd_total;
      pulse(tbl[i].mv);
      wait_idle($sformatf("vec%0d_idle", i));
      check($sformatf("vec%0d_x", i), piece_x, tbl[i].ex);
      check($sformatf("vec%0d_y", i), piece_y, tbl[i].ey);
      check($sformatf("vec%0d_rot", i), piece_rot, tbl[i].erot);
      check($sformatf("vec%0d_reads", i), rd_total - rd0, tbl[i].ereads);
      $display("vec %0d: mv=%0d -> x=%0d y=%0d rot=%0d reads=%0d",
               i, tbl[i].mv, piece_x, piece_y, piece_rot, rd_total - rd0);
    end

    // Walk to the left wall, then a left move that would put a block at column -1
    for (int i = 0; i < 6; i++) begin
      pulse(2);
      wait_idle("walk_left_idle");
    end
    check("walk_left_x", piece_x, 1);
    rd0 = rd_total;
    pulse(2);
    wait_idle("left_wall_idle");
    check("left_wall_x", piece_x, 1);
    check("left_wall_reads", rd_total - rd0, 3);
    $display("left wall: x=%0d reads=%0d", piece_x, rd_total - rd0);

    // Occupied cell (5,2) blocks a right move from (4,1); empty board accepts it
    do_reset();
    occ_map[2][5] = 1'b1;
    pulse(3);
    wait_idle("occ_idle");
    check("occ_blocked_x", piece_x, 4);
    occ_map[2][5] = 1'b0;
    pulse(3);
    wait_idle("occ_free_idle");
    check("occ_free_x", piece_x, 5);
    $display("occupancy: blocked then free -> x=%0d", piece_x);

    // Rotate and drop requested together: drop wins, rotation is discarded
    do_reset();
    @(negedge clk);
    drop_tick = 1'b1; req_rot = 1'b1;
    @(posedge clk);
    #1;
    drop_tick = 1'b0; req_rot = 1'b0;
    wait_idle("rotdrop_idle");
    check("rotdrop_y", piece_y, 2);
    check("rotdrop_rot", piece_rot, 0);
    repeat (10) @(negedge clk);
    check("rotdrop_rot_later", piece_rot, 0);
    check("rotdrop_busy_later", busy, 0);
    pulse(1);
    wait_idle("rot_after_idle");
    check("rot_after_rot", piece_rot, 1);
    @(negedge clk);
    check("rot_after_shp_rot", shp_rot, 1);
    $display("rot+drop: y=%0d rot=%0d", piece_y, piece_rot);

    // Drop to row 18 then a drop whose stem would reach row 20 locks the piece
    do_reset();
    for (int i = 0; i < 17; i++) begin
      pulse(0);
      wait_idle("fall_idle");
    end
    check("fall_y", piece_y, 18);
    pulse(0);
    n = 0;
    seen = 1'b0;
    while (!seen && n < 20) begin
      @(negedge clk);
      seen = lock_pulse;
      n++;
    end
    check("lock_seen", seen, 1);
    check("lock_y_during", piece_y, 18);
    @(negedge clk);
    check("lock_width", lock_pulse, 0);
    check("respawn_x", piece_x, 4);
    check("respawn_y", piece_y, 1);
    check("respawn_rot", piece_rot, 0);
    wait_idle("respawn_idle");
    check("respawn_game_over", game_over, 0);
    check("respawn_lock_quiet", lock_pulse, 0);
    $display("lock: respawned at x=%0d y=%0d rot=%0d", piece_x, piece_y, piece_rot);

    // Blocked drop at spawn whose respawn also collides: sticky game over
    do_reset();
    occ_map[2][4] = 1'b1;
    pulse(0);
    wait_idle("go_idle");
    check("go_flag", game_over, 1);
    check("go_x", piece_x, 4);
    check("go_y", piece_y, 1);
    pulse(3);
    pulse(1);
    pulse(0);
    seen = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (busy) seen = 1'b1;
    end
    check("go_ignores_busy", seen, 0);
    check("go_ignores_x", piece_x, 4);
    check("go_ignores_rot", piece_rot, 0);
    check("go_sticky", game_over, 1);
    occ_map[2][4] = 1'b0;
    do_reset();
    @(negedge clk);
    check("go_cleared", game_over, 0);
    $display("game over: sticky until reset, now %0d", game_over);

    // Reset in the middle of a check aborts the move
    pulse(3);
    wait_idle("pre_abort_idle");
    check("pre_abort_x", piece_x, 5);
    pulse(3);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_x", piece_x, 4);
    check("abort_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("abort_x_later", piece_x, 4);
    check("abort_lock", lock_pulse, 0);
    $display("abort: x=%0d busy=%0d", piece_x, busy);

    check("oob_reads", oob_reads, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
